mem_port: RTL and testbench
===========================

# mem_port

Parametrised single-port synchronous memory with a CPU-side request interface, configurable read latency, byte-lane write enables and a `locked` ready output. It sits between `x86cpu` (or any bus master) and on-chip RAM. It generalises the fixed two-stage, byte-wide simulation memory into a synthesizable block with a defined handshake and an optional post-reset clear sequence.

## Interface

- `ADDR_W`, 20, address width in words.
- `DATA_W`, 8, word width; multiple of 8.
- `DEPTH`, 1 << ADDR_W, number of implemented words; must be ≤ 2^ADDR_W.
- `LATENCY`, 2, read latency in cycles; legal range 1..8.
- `FILL`, 0, word written by the clear sequence; only used with `MEM_CLEAR_EN`.
- `clock` in 1: sole clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `locked` out 1: block accepts requests; 0 during reset and clear.
- `cpu_addr` in ADDR_W: word address.
- `cpu_rd` in 1: read request.
- `cpu_wr` in 1: write request.
- `cpu_be` in DATA_W/8: byte-lane write enables; bit k covers bits [8k+7:8k].
- `cpu_wdata` in DATA_W: write data.
- `cpu_rdata` out DATA_W: read data.
- `cpu_rvalid` out 1: `cpu_rdata` carries a read result this cycle.

## Operation

- Request accepted in any cycle with `locked`=1 and (`cpu_rd` or `cpu_wr`). No backpressure once `locked`=1; one request per cycle, fully pipelined.
- Write: lanes with `cpu_be[k]`=1 are updated at the accepting edge; other lanes are unchanged. No `cpu_rvalid` is produced.
- `cpu_rd` and `cpu_wr` both high: the write is performed and the read is dropped (no `cpu_rvalid`).
- Read: the word at `cpu_addr` is sampled at the accepting edge. It appears on `cpu_rdata` with `cpu_rvalid`=1 exactly LATENCY cycles later.
- Read-after-write to the same address in consecutive cycles returns the new data (write-first).
- `cpu_addr` ≥ DEPTH: writes are ignored; reads return 0 with normal latency and `cpu_rvalid`.
- `cpu_rdata` holds its last value while `cpu_rvalid`=0.
- Requests while `locked`=0 are ignored entirely.
- State machine: RESET → (CLEAR if `MEM_CLEAR_EN`) → RUN. RUN is left only by `reset`.

## Timing

- Reset values: `locked`=0, `cpu_rvalid`=0, `cpu_rdata`=0. The valid pipeline is flushed.
- Memory contents are not altered by reset itself.
- Without clear: `locked`=1 from the first edge after `reset` deasserts.
- With clear: see Configuration.
- Reset asserted mid-operation: all in-flight reads are discarded and no `cpu_rvalid` is emitted for them.
- Reset during CLEAR: the clear restarts from address 0 after `reset` deasserts.
- Read accepted at edge N: `cpu_rvalid`=1 during the cycle following edge N+LATENCY−1. This is a LATENCY-deep register pipeline of valid and data.
- Back-to-back reads produce back-to-back `cpu_rvalid` pulses in request order.

## Configuration

- `MEM_CLEAR_EN` defined: after `reset` deasserts, the CLEAR state writes FILL (all lanes) to addresses 0..DEPTH−1, one word per cycle.
  - `locked`=0 throughout CLEAR.
  - `locked` rises on the cycle after the last write, DEPTH cycles after reset release.
- `MEM_CLEAR_EN` undefined: CLEAR state and its address counter are not built. Memory powers up with simulator/FPGA initial contents.

## Test plan

- Reset then idle, no macro: `locked`=0 while `reset`=1. `locked`=1 on the first cycle after release. `cpu_rvalid`=0 throughout.
- Write 0xA5 to addr 0x00010, then read 0x00010 next cycle (DATA_W=8, LATENCY=2): `cpu_rvalid`=1 with `cpu_rdata`=0xA5 two cycles after the read edge.
- DATA_W=16: write 0x1234 with be=11, then 0xFF00 with be=10, then read: result 0xFF34.
- Reads to addr 1, 2, 3 on consecutive cycles, LATENCY=3: three consecutive `cpu_rvalid` pulses in order 1, 2, 3. Assert `reset` one cycle after the third read: no further `cpu_rvalid`.
- DEPTH=16, ADDR_W=8: write 0x77 to addr 0x20, then read 0x20: `cpu_rdata`=0 with `cpu_rvalid`=1. Addr 0x00 is unchanged.
- `MEM_CLEAR_EN`, DEPTH=16, FILL=0x5A:
  - `locked` stays 0 for 16 cycles after release.
  - A read of addr 15 issued during CLEAR is ignored.
  - After `locked`=1, a read of addr 15 returns 0x5A.

Source files
------------

// File: rtl/mem_port.sv
// Single-port synchronous RAM with a pipelined CPU request port and byte-lane writes.
// Optional post-reset fill of the whole array is built when MEM_CLEAR_EN is defined.
module mem_port #(
    parameter int              ADDR_W  = 20,
    parameter int              DATA_W  = 8,
    parameter int              DEPTH   = 1 << ADDR_W,
    parameter int              LATENCY = 2,
    parameter logic [DATA_W-1:0] FILL  = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  locked,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic [DATA_W/8-1:0]   cpu_be,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_rvalid
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_RESET,
`ifdef MEM_CLEAR_EN
        ST_CLEAR,
`endif
        ST_RUN
    } state_t;

    state_t                         state_q, state_d;
    logic                           locked_q, locked_d;
    logic [LATENCY-1:0]             vld_q, vld_d;
    logic [LATENCY-1:0][DATA_W-1:0] dat_q, dat_d;

`ifdef MEM_CLEAR_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    logic [IDX_W-1:0]               clr_addr_q, clr_addr_d;
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              accept_rd;
    logic [DATA_W-1:0] rd_word;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [NB-1:0]     mem_wbe;

    assign in_range  = {1'b0, cpu_addr} < DEPTH_L;
    assign idx       = cpu_addr[IDX_W-1:0];
    assign accept_rd = locked_q & cpu_rd & ~cpu_wr;
    assign rd_word   = in_range ? mem[idx] : '0;

    always_comb begin
        mem_we    = locked_q & cpu_wr & in_range & ~reset;
        mem_waddr = idx;
        mem_wdata = cpu_wdata;
        mem_wbe   = cpu_be;
`ifdef MEM_CLEAR_EN
        if (state_q == ST_CLEAR && !reset) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
            mem_wdata = FILL;
            mem_wbe   = '1;
        end
`endif
    end

    // Memory contents are deliberately outside the reset domain.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int k = 0; k < NB; k++) begin
                if (mem_wbe[k]) begin
                    mem[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        locked_d = locked_q;
`ifdef MEM_CLEAR_EN
        clr_addr_d = clr_addr_q;
`endif
        case (state_q)
            ST_RESET: begin
`ifdef MEM_CLEAR_EN
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
`else
                state_d  = ST_RUN;
                locked_d = 1'b1;
`endif
            end
`ifdef MEM_CLEAR_EN
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + IDX_W'(1);
                if (clr_addr_q == LAST_IDX) begin
                    state_d  = ST_RUN;
                    locked_d = 1'b1;
                end
            end
`endif
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d  = ST_RESET;
                locked_d = 1'b0;
            end
        endcase
    end

    // Output stage only reloads on a valid result so cpu_rdata holds between reads.
    always_comb begin
        vld_d    = '0;
        dat_d    = dat_q;
        vld_d[0] = accept_rd;
        dat_d[0] = rd_word;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
        if (!vld_d[LATENCY-1]) begin
            dat_d[LATENCY-1] = dat_q[LATENCY-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_RESET;
            locked_q <= 1'b0;
            vld_q    <= '0;
            dat_q    <= '0;
`ifdef MEM_CLEAR_EN
            clr_addr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            locked_q <= locked_d;
            vld_q    <= vld_d;
            dat_q    <= dat_d;
`ifdef MEM_CLEAR_EN
            clr_addr_q <= clr_addr_d;
`endif
        end
    end

    assign locked     = locked_q;
    assign cpu_rvalid = vld_q[LATENCY-1];
    assign cpu_rdata  = dat_q[LATENCY-1];

endmodule

// File: tb/tb_mem_port.sv
// Bench for mem_port (DEPTH=16, DATA_W=16, LATENCY=3) with a schedule-based reference model.
// Define MEM_CLEAR_EN for both files to exercise the post-reset fill.
module tb_mem_port;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;
    localparam int DEPTH   = 16;
    localparam int LATENCY = 3;
    localparam logic [15:0] FILL = 16'h005A;
`ifdef MEM_CLEAR_EN
    localparam int CLR_CYC = DEPTH;
    localparam logic [15:0] AFTER_RST1 = 16'h005A;
    localparam logic [15:0] AFTER_RST2 = 16'h005A;
`else
    localparam int CLR_CYC = 0;
    localparam logic [15:0] AFTER_RST1 = 16'h1001;
    localparam logic [15:0] AFTER_RST2 = 16'h1002;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        locked;
    logic [7:0]  cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [1:0]  cpu_be;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_rvalid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mem_port #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .LATENCY(LATENCY), .FILL(FILL)
    ) dut (
        .clock(clock), .reset(reset), .locked(locked),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_be(cpu_be), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid)
    );

    // Reference model: each accepted read books its result for an absolute cycle.
    int          cyc = 0;
    bit          exp_v  [4096];
    logic [15:0] exp_d  [4096];
    bit          exp_dk [4096];
    logic [15:0] m_mem   [16];
    logic [1:0]  m_known [16];
    bit          m_locked = 1'b0;
    logic [15:0] m_rdata = '0;
    bit          m_rdata_known = 1'b0;
    int          rel_cnt = -1;
    bit          prev_locked;
    int          slot;

    initial begin
        for (int a = 0; a < 16; a++) m_known[a] = 2'b00;
    end

    always @(posedge clock) begin
        cyc++;
        prev_locked = m_locked;
        if (reset) begin
            rel_cnt  = -1;
            m_locked = 1'b0;
            for (int k = cyc; k <= cyc + LATENCY && k < 4096; k++) exp_v[k] = 1'b0;
            m_rdata       = '0;
            m_rdata_known = 1'b1;
        end else begin
            if (prev_locked && cpu_wr) begin
                if (cpu_addr < DEPTH) begin
                    for (int b = 0; b < 2; b++) begin
                        if (cpu_be[b]) begin
                            m_mem[cpu_addr[3:0]][8*b +: 8] = cpu_wdata[8*b +: 8];
                            m_known[cpu_addr[3:0]][b] = 1'b1;
                        end
                    end
                end
            end else if (prev_locked && cpu_rd) begin
                slot = cyc + LATENCY - 1;
                exp_v[slot] = 1'b1;
                if (cpu_addr < DEPTH) begin
                    exp_d[slot]  = m_mem[cpu_addr[3:0]];
                    exp_dk[slot] = &m_known[cpu_addr[3:0]];
                end else begin
                    exp_d[slot]  = '0;
                    exp_dk[slot] = 1'b1;
                end
            end
            if (rel_cnt < 100000) rel_cnt++;
            if (!m_locked && rel_cnt >= CLR_CYC) begin
                m_locked = 1'b1;
                if (CLR_CYC > 0) begin
                    for (int a = 0; a < 16; a++) begin
                        m_mem[a]   = FILL;
                        m_known[a] = 2'b11;
                    end
                end
            end
            if (exp_v[cyc]) begin
                m_rdata       = exp_d[cyc];
                m_rdata_known = exp_dk[cyc];
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (cyc > 0 && cyc < 4096) begin
            check_output("model locked", 32'(locked), 32'(m_locked));
            check_output("model rvalid", 32'(cpu_rvalid), 32'(exp_v[cyc]));
            if (m_rdata_known) check_output("model rdata", 32'(cpu_rdata), 32'(m_rdata));
        end
    end

    task automatic apply_stimulus(input logic rd, input logic wr, input logic [7:0] addr,
                                  input logic [1:0] be, input logic [15:0] wdata);
        cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_be = be; cpu_wdata = wdata;
        @(posedge clock);
        #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic wait_rvalid(input string name, input int exp_wait, input logic [15:0] exp_data);
        int i;
        for (i = 1; i <= 12; i++) begin
            @(negedge clock);
            if (cpu_rvalid) break;
        end
        check_output({name, " latency"}, 32'(i), 32'(exp_wait));
        check_output({name, " data"}, 32'(cpu_rdata), 32'(exp_data));
    endtask

    logic [15:0] rv_q[$];

    task automatic collect(input int ncyc);
        rv_q.delete();
        repeat (ncyc) begin
            @(negedge clock);
            if (cpu_rvalid) rv_q.push_back(cpu_rdata);
        end
    endtask

    task automatic release_reset(input logic rd, input logic wr, input logic [7:0] addr,
                                 input logic [15:0] wdata);
        int n;
        @(negedge clock);
        reset = 1'b0;
        cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_be = 2'b11; cpu_wdata = wdata;
        @(posedge clock);
        #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (locked) break;
            n++;
        end
        check_output("lock delay", 32'(n), 32'(CLR_CYC));
    endtask

    initial begin
        reset = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0;
        cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;

        repeat (3) @(negedge clock);
        check_output("reset locked", 32'(locked), 32'd0);
        check_output("reset rvalid", 32'(cpu_rvalid), 32'd0);
        check_output("reset rdata", 32'(cpu_rdata), 32'd0);

        // A read presented on the release edge is ignored since locked is still low.
        release_reset(1'b1, 1'b0, 8'd15, 16'h0000);
`ifdef MEM_CLEAR_EN
        apply_stimulus(1'b1, 1'b0, 8'd15, 2'b00, 16'h0000);
        wait_rvalid("fill read", LATENCY, 16'h005A);
`endif

        for (int i = 0; i < 16; i++) apply_stimulus(1'b0, 1'b1, 8'(i), 2'b11, 16'h1000 + 16'(i));

        apply_stimulus(1'b0, 1'b1, 8'h0A, 2'b11, 16'h00A5);
        apply_stimulus(1'b1, 1'b0, 8'h0A, 2'b00, 16'h0000);
        wait_rvalid("raw", LATENCY, 16'h00A5);

        apply_stimulus(1'b0, 1'b1, 8'h05, 2'b11, 16'h1234);
        apply_stimulus(1'b0, 1'b1, 8'h05, 2'b10, 16'hFF00);
        apply_stimulus(1'b1, 1'b0, 8'h05, 2'b00, 16'h0000);
        wait_rvalid("upper lane", LATENCY, 16'hFF34);

        apply_stimulus(1'b0, 1'b1, 8'h06, 2'b01, 16'hABCD);
        apply_stimulus(1'b1, 1'b0, 8'h06, 2'b00, 16'h0000);
        wait_rvalid("lower lane", LATENCY, 16'h10CD);

        apply_stimulus(1'b0, 1'b1, 8'h20, 2'b11, 16'h7777);
        apply_stimulus(1'b0, 1'b1, 8'h10, 2'b11, 16'h8888);
        apply_stimulus(1'b1, 1'b0, 8'h20, 2'b00, 16'h0000);
        wait_rvalid("oob read", LATENCY, 16'h0000);
        apply_stimulus(1'b1, 1'b0, 8'h00, 2'b00, 16'h0000);
        wait_rvalid("alias 0", LATENCY, 16'h1000);
        apply_stimulus(1'b1, 1'b0, 8'h10, 2'b00, 16'h0000);
        wait_rvalid("oob edge", LATENCY, 16'h0000);
        apply_stimulus(1'b1, 1'b0, 8'h0F, 2'b00, 16'h0000);
        wait_rvalid("last word", LATENCY, 16'h100F);

        apply_stimulus(1'b1, 1'b1, 8'h07, 2'b11, 16'h4444);
        collect(6);
        check_output("rdwr pulses", 32'(rv_q.size()), 32'd0);
        apply_stimulus(1'b1, 1'b0, 8'h07, 2'b00, 16'h0000);
        wait_rvalid("rdwr data", LATENCY, 16'h4444);

        for (int i = 1; i <= 3; i++) apply_stimulus(1'b1, 1'b0, 8'(i), 2'b00, 16'h0000);
        collect(8);
        check_output("b2b count", 32'(rv_q.size()), 32'd3);
        if (rv_q.size() == 3) begin
            check_output("b2b first", 32'(rv_q[0]), 32'h1001);
            check_output("b2b second", 32'(rv_q[1]), 32'h1002);
            check_output("b2b third", 32'(rv_q[2]), 32'h1003);
        end

        // Reset lands one edge after the third read: only the oldest result escapes.
        for (int i = 1; i <= 3; i++) apply_stimulus(1'b1, 1'b0, 8'(i), 2'b00, 16'h0000);
        reset = 1'b1;
        collect(6);
        check_output("flush count", 32'(rv_q.size()), 32'd1);
        check_output("flush locked", 32'(locked), 32'd0);
        check_output("flush rdata", 32'(cpu_rdata), 32'd0);

        release_reset(1'b0, 1'b1, 8'h01, 16'hDEAD);
        apply_stimulus(1'b1, 1'b0, 8'h01, 2'b00, 16'h0000);
        wait_rvalid("ignored write", LATENCY, AFTER_RST1);
        apply_stimulus(1'b1, 1'b0, 8'h02, 2'b00, 16'h0000);
        wait_rvalid("kept contents", LATENCY, AFTER_RST2);

        repeat (4) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
